// File: rtl/keccak_absorb_buffer_pkg.sv
// Shared definitions for the Keccak absorb buffer.
//   - absorb_state_e : buffer state encoding (FILL / PAD / FULL)
//   - keccak_lanes / keccak_drain_cycles : derived geometry
//   - keccak_params_ok : legality of RATE / W / ABSORB_SLICES
//   - keccak_pad_mask : pad10*1 bits for a block ending at lane_cnt
package keccak_absorb_buffer_pkg;

  localparam int KECCAK_MAX_LANES = 25;
  localparam int KECCAK_MAX_BITS  = 1600;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_FULL = 2'd2
  } absorb_state_e;

  function automatic int keccak_lanes(input int rate, input int w);
    return rate / w;
  endfunction

  function automatic int keccak_drain_cycles(input int w, input int slices);
    return w / slices;
  endfunction

  function automatic bit keccak_params_ok(input int rate, input int w, input int slices);
    return (w > 0) && (slices > 0) && (rate > 0) &&
           (rate % w == 0) && (w % slices == 0) &&
           (rate / w <= KECCAK_MAX_LANES) && (rate <= KECCAK_MAX_BITS);
  endfunction

  // Flat block image (lane i at [i*w +: w]) holding only the two pad bits:
  // the leading 1 at bit 0 of lane lane_cnt and the trailing 1 at the top
  // bit of the last lane. The two OR together when they share a lane.
  function automatic logic [KECCAK_MAX_BITS-1:0] keccak_pad_mask(input int lane_cnt,
                                                                  input int lanes,
                                                                  input int w);
    logic [KECCAK_MAX_BITS-1:0] m;
    m = '0;
    m = m | (KECCAK_MAX_BITS'(1) << (lane_cnt * w));
    m = m | (KECCAK_MAX_BITS'(1) << (lanes * w - 1));
    return m;
  endfunction

endpackage

// File: rtl/keccak_absorb_buffer.sv
// Keccak absorb buffer: gathers message lanes from a valid/ready stream into
// one rate block, applies pad10*1 on the final block, and lets the round
// controller drain it ABSORB_SLICES slices per enable pulse.
// Ports:
//   ClkxCI, RstxRBI            clock, async active-low reset
//   InDataxDI/InValidxSI/
//   InLastxSI/InReadyxSO       lane input stream (last qualified by valid)
//   ctrl_clear                 sync clear back to empty FILL
//   ctrl_enable_absorb         consume current slice group (FULL only)
//   BlockValidxSO/BlockLastxSO block held / block is final of message
//   AbsorbSlicesxDO            low ABSORB_SLICES bits of every lane
module keccak_absorb_buffer
  import keccak_absorb_buffer_pkg::*;
#(
  parameter int RATE          = 128,
  parameter int W             = 16,
  parameter int ABSORB_SLICES = W
) (
  input  logic                                  ClkxCI,
  input  logic                                  RstxRBI,
  input  logic [W-1:0]                          InDataxDI,
  input  logic                                  InValidxSI,
  input  logic                                  InLastxSI,
  output logic                                  InReadyxSO,
  input  logic                                  ctrl_clear,
  input  logic                                  ctrl_enable_absorb,
  output logic                                  BlockValidxSO,
  output logic                                  BlockLastxSO,
  output logic [RATE/W*ABSORB_SLICES-1:0]       AbsorbSlicesxDO
);

  localparam int LANES        = keccak_lanes(RATE, W);
  localparam int DRAIN_CYCLES = keccak_drain_cycles(W, ABSORB_SLICES);
  // lane_cnt reaches LANES after the final lane of a full block
  localparam int LCW          = $clog2(LANES + 1);
  localparam int SCW          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  if (!keccak_params_ok(RATE, W, ABSORB_SLICES)) begin : g_bad_params
    $error("keccak_absorb_buffer: illegal RATE/W/ABSORB_SLICES");
  end

  absorb_state_e               state_q, state_d;
  logic [LANES-1:0][W-1:0]     lane_q, lane_d;
  logic [LCW-1:0]              lane_cnt_q, lane_cnt_d;
  logic [SCW-1:0]              slice_cnt_q, slice_cnt_d;
  logic                        last_q, last_d;
  logic                        pad_pend_q, pad_pend_d;
  logic [RATE-1:0]             pad_bits;

  assign pad_bits = RATE'(keccak_pad_mask(int'(lane_cnt_q), LANES, W));

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    lane_cnt_d    = lane_cnt_q;
    slice_cnt_d   = slice_cnt_q;
    last_d        = last_q;
    pad_pend_d    = pad_pend_q;
    InReadyxSO    = 1'b0;
    BlockValidxSO = 1'b0;

    case (state_q)
      ST_FILL: begin
        InReadyxSO = 1'b1;
        if (InValidxSI) begin
          for (int i = 0; i < LANES; i++)
            if (lane_cnt_q == LCW'(i)) lane_d[i] = InDataxDI;
          lane_cnt_d = lane_cnt_q + LCW'(1);
          if (lane_cnt_q == LCW'(LANES - 1)) begin
            // a final lane that fills the block leaves no room for padding,
            // so a pad-only block is queued behind it
            state_d    = ST_FULL;
            last_d     = 1'b0;
            pad_pend_d = InLastxSI;
          end else if (InLastxSI) begin
            state_d = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        for (int i = 0; i < LANES; i++)
          if (LCW'(i) >= lane_cnt_q) lane_d[i] = pad_bits[i*W +: W];
        last_d  = 1'b1;
        state_d = ST_FULL;
      end

      ST_FULL: begin
        BlockValidxSO = 1'b1;
        if (ctrl_enable_absorb) begin
          for (int i = 0; i < LANES; i++)
            lane_d[i] = lane_q[i] >> ABSORB_SLICES;
          if (slice_cnt_q == SCW'(DRAIN_CYCLES - 1)) begin
            lane_cnt_d  = '0;
            slice_cnt_d = '0;
            last_d      = 1'b0;
            if (pad_pend_q) begin
              state_d    = ST_PAD;
              pad_pend_d = 1'b0;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            slice_cnt_d = slice_cnt_q + SCW'(1);
          end
        end
      end

      default: state_d = ST_FILL;
    endcase

    if (ctrl_clear) begin
      state_d     = ST_FILL;
      lane_d      = '0;
      lane_cnt_d  = '0;
      slice_cnt_d = '0;
      last_d      = 1'b0;
      pad_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      state_q     <= ST_FILL;
      lane_q      <= '0;
      lane_cnt_q  <= '0;
      slice_cnt_q <= '0;
      last_q      <= 1'b0;
      pad_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      lane_cnt_q  <= lane_cnt_d;
      slice_cnt_q <= slice_cnt_d;
      last_q      <= last_d;
      pad_pend_q  <= pad_pend_d;
    end
  end

  assign BlockLastxSO = (state_q == ST_FULL) && last_q;

  for (genvar i = 0; i < LANES; i++) begin : g_slices
    assign AbsorbSlicesxDO[i*ABSORB_SLICES +: ABSORB_SLICES] = lane_q[i][ABSORB_SLICES-1:0];
  end

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// Bench for keccak_absorb_buffer: one parallel-drain instance (ABSORB_SLICES=W)
// and one bit-serial instance (ABSORB_SLICES=1) share a clock and a stimulus
// bus; sel picks which one is driven and observed. Expected blocks come from
// a queue-level pad10*1 model of the whole message.
module tb_keccak_absorb_buffer;
  localparam int W     = 16;
  localparam int RATE  = 128;
  localparam int LANES = RATE / W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sel = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, clr = 1'b0, absorb = 1'b0;

  logic          p_ready, p_bvalid, p_blast;
  logic          s_ready, s_bvalid, s_blast;
  logic [LANES*W-1:0] p_abs;
  logic [LANES-1:0]   s_abs;

  keccak_absorb_buffer #(.RATE(RATE), .W(W), .ABSORB_SLICES(W)) dut_p (
    .ClkxCI(clk), .RstxRBI(rst_n), .InDataxDI(in_data),
    .InValidxSI(in_valid & ~sel), .InLastxSI(in_last), .InReadyxSO(p_ready),
    .ctrl_clear(clr & ~sel), .ctrl_enable_absorb(absorb & ~sel),
    .BlockValidxSO(p_bvalid), .BlockLastxSO(p_blast), .AbsorbSlicesxDO(p_abs));

  keccak_absorb_buffer #(.RATE(RATE), .W(W), .ABSORB_SLICES(1)) dut_s (
    .ClkxCI(clk), .RstxRBI(rst_n), .InDataxDI(in_data),
    .InValidxSI(in_valid & sel), .InLastxSI(in_last), .InReadyxSO(s_ready),
    .ctrl_clear(clr & sel), .ctrl_enable_absorb(absorb & sel),
    .BlockValidxSO(s_bvalid), .BlockLastxSO(s_blast), .AbsorbSlicesxDO(s_abs));

  wire               ready  = sel ? s_ready  : p_ready;
  wire               bvalid = sel ? s_bvalid : p_bvalid;
  wire               blast  = sel ? s_blast  : p_blast;
  wire [LANES*W-1:0] absd   = sel ? {{(LANES*W-LANES){1'b0}}, s_abs} : p_abs;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] msg_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [W-1:0] d, input logic l);
    int g = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!ready && g < 20) begin step(); g++; end
    chk("feed_ready", ready, 1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_blast"}, blast, 0);
    chk({tag, "_abs"}, absd, 0);
  endtask

  // Sends msg_q to the selected instance and drains/checks every block.
  task automatic run_msg();
    logic [W-1:0] q[$];
    int n, nblk, as, dc, base, nm, nm_next, lat, g;
    logic [127:0] exp;
    n = msg_q.size();
    q = msg_q;
    q.push_back(16'h0001);
    while (q.size() % LANES != 0) q.push_back('0);
    q[q.size()-1] = q[q.size()-1] | 16'h8000;
    nblk = q.size() / LANES;
    as = sel ? 1 : W;
    dc = W / as;
    for (int b = 0; b < nblk; b++) begin
      base = b * LANES;
      nm = (n - base > LANES) ? LANES : ((n - base > 0) ? n - base : 0);
      for (int j = 0; j < nm; j++) begin
        if ($urandom_range(3) == 0) begin
          absorb = 1'b1; step(); absorb = 1'b0;  // must be ignored in FILL
        end
        feed(msg_q[base + j], (base + j) == n - 1);
      end
      lat = 1;
      g = 0;
      while (!bvalid && g < 20) begin
        in_valid = 1'($urandom_range(1)); in_data = W'($urandom); in_last = 1'($urandom);
        step(); lat++; g++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("blk_valid", bvalid, 1);
      if (nm > 0) chk("latency", lat, (nm == LANES) ? 1 : 2);
      chk("blk_last", blast, (b == nblk - 1));
      chk("full_ready", ready, 0);
      for (int k = 0; k < dc; k++) begin
        exp = '0;
        for (int i = 0; i < LANES; i++)
          exp = exp | (128'((q[base+i] >> (k*as)) & ((17'h1 << as) - 1)) << (i*as));
        chk(sel ? "slice_bit" : "block_lanes", absd, exp);
        chk("drain_valid", bvalid, 1);
        chk("drain_ready", ready, 0);
        in_valid = 1'b0;
        absorb = 1'b1; step(); absorb = 1'b0;
        if (k < dc - 1) begin
          g = $urandom_range(2);
          for (int z = 0; z < g; z++) begin
            in_valid = 1'($urandom_range(1)); in_data = W'($urandom);
            step();
          end
          in_valid = 1'b0;
        end
      end
      nm_next = (n - base - LANES > 0) ? 1 : 0;
      chk("post_drain_valid", bvalid, 0);
      chk("post_drain_ready", ready, (b + 1 < nblk && nm_next == 0) ? 0 : 1);
    end
  endtask

  task automatic rand_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(W'($urandom));
  endtask

  initial begin
    int seen;
    #12;
    sel = 1'b0; check_idle("rst_p");
    sel = 1'b1; check_idle("rst_s");
    rst_n = 1'b1;
    step();

    sel = 1'b0;
    msg_q.delete();
    for (int i = 0; i < 8; i++) msg_q.push_back(W'(i + 1));
    run_msg();
    msg_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_msg();
    rand_msg(7);
    run_msg();
    for (int r = 0; r < 12; r++) begin
      rand_msg($urandom_range(1, 20));
      run_msg();
    end

    sel = 1'b1;
    rand_msg(8);
    run_msg();
    for (int r = 0; r < 4; r++) begin
      rand_msg($urandom_range(1, 12));
      run_msg();
    end

    // clear on the 5th drain pulse of a block that has a pad block pending
    rand_msg(8);
    for (int j = 0; j < 8; j++) feed(msg_q[j], j == 7);
    chk("clr_pre_valid", bvalid, 1);
    for (int k = 0; k < 4; k++) begin absorb = 1'b1; step(); absorb = 1'b0; end
    absorb = 1'b1; clr = 1'b1; step(); absorb = 1'b0; clr = 1'b0;
    check_idle("clr");
    seen = 0;
    for (int k = 0; k < 10; k++) begin step(); if (bvalid) seen++; end
    chk("clr_no_pad", seen, 0);
    rand_msg(3);
    run_msg();

    // async reset while a pad block is pending
    sel = 1'b0;
    rand_msg(8);
    for (int j = 0; j < 8; j++) feed(msg_q[j], j == 7);
    chk("rst_pre_valid", bvalid, 1);
    #2 rst_n = 1'b0;
    #1 check_idle("arst");
    @(negedge clk); rst_n = 1'b1;
    step();
    seen = 0;
    for (int k = 0; k < 10; k++) begin step(); if (bvalid) seen++; end
    chk("arst_no_pad", seen, 0);
    check_idle("arst_after");
    rand_msg(5);
    run_msg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1);
  end
endmodule
